// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
//   Shared game-datapath constants and types.
//   - Velocity and angle field widths used by the collision datapath.
//   - Default timing for the collision commit stage.
//   - State encoding for collision_commit.
//   - counter_width(): bits needed to hold 0..max_value (never less than 1).
// -----------------------------------------------------------------------------
package game_pkg;

  // Fixed-point velocity format: signed integer part plus fraction bits.
  localparam int VELOCITY_INTEGER_WIDTH  = 8;
  localparam int VELOCITY_FRACTION_WIDTH = 8;

  // Signed heading in degrees, 0..359.
  localparam int ANGLE_BITS = 10;

  // The upstream sqrt/angle iteration needs this many cycles to settle.
  localparam int COLLISION_SETTLE_CYCLES   = 40;
  // Frames during which new collisions are ignored after a commit.
  localparam int COLLISION_COOLDOWN_FRAMES = 8;

  typedef enum logic [1:0] {
    CC_IDLE,
    CC_SETTLE,
    CC_HOLD,
    CC_COOLDOWN
  } collision_commit_state_t;

  function automatic int counter_width(input int unsigned max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/collision_cooldown_timer.sv
// -----------------------------------------------------------------------------
// collision_cooldown_timer
//   Frame-tick down counter. Loads a start value, decrements once per tick
//   and stops at zero.
//   Ports:
//     i_clk, i_rst_n   clock, asynchronous active-low reset (count -> 0)
//     i_load           load i_load_value (has priority over i_tick)
//     i_load_value     start value
//     i_tick           decrement request (ignored when already zero)
//     o_zero           count is zero
// -----------------------------------------------------------------------------
module collision_cooldown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_tick,
  output logic             o_zero
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge value of every other register, independent of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (i_load) begin
      count <= i_load_value;
    end else if (i_tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign o_zero = (count == '0);

endmodule

// File: rtl/collision_commit.sv
// -----------------------------------------------------------------------------
// collision_commit
//   Waits for a collision to persist long enough for the upstream velocity and
//   angle results to settle, then snapshots them into output registers and
//   holds them until the consumer acknowledges. After an acknowledge, new
//   collisions are ignored for a number of frame ticks.
//   Ports:
//     i_clk, i_rst_n         clock, asynchronous active-low reset
//     i_frame_tick           one-cycle pulse per game frame
//     i_collision            collision flag from the upstream stage
//     i_car*_v_x/_v_y/_v_m   signed velocity components / magnitudes (VW)
//     i_car*_angle           signed heading, degrees (ANG_WIDTH)
//     i_ack                  consumer accepts the committed result
//     o_valid                committed result available (state HOLD)
//     o_car*_*               committed copies of the value inputs
//     o_busy                 any state other than IDLE
//     o_collision_count      committed collisions, saturating at 255
//   SETTLE_CYCLES must be at least 1.
// -----------------------------------------------------------------------------
module collision_commit
  import game_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES   = COLLISION_SETTLE_CYCLES,
  parameter int unsigned COOLDOWN_FRAMES = COLLISION_COOLDOWN_FRAMES,
  localparam int VW        = VELOCITY_INTEGER_WIDTH + VELOCITY_FRACTION_WIDTH,
  localparam int ANG_WIDTH = ANGLE_BITS
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_frame_tick,
  input  logic                        i_collision,
  input  logic signed [VW-1:0]        i_car1_v_x,
  input  logic signed [VW-1:0]        i_car1_v_y,
  input  logic signed [VW-1:0]        i_car2_v_x,
  input  logic signed [VW-1:0]        i_car2_v_y,
  input  logic signed [VW-1:0]        i_car1_v_m,
  input  logic signed [VW-1:0]        i_car2_v_m,
  input  logic signed [ANG_WIDTH-1:0] i_car1_angle,
  input  logic signed [ANG_WIDTH-1:0] i_car2_angle,
  input  logic                        i_ack,
  output logic                        o_valid,
  output logic signed [VW-1:0]        o_car1_v_x,
  output logic signed [VW-1:0]        o_car1_v_y,
  output logic signed [VW-1:0]        o_car2_v_x,
  output logic signed [VW-1:0]        o_car2_v_y,
  output logic signed [VW-1:0]        o_car1_v_m,
  output logic signed [VW-1:0]        o_car2_v_m,
  output logic signed [ANG_WIDTH-1:0] o_car1_angle,
  output logic signed [ANG_WIDTH-1:0] o_car2_angle,
  output logic                        o_busy,
  output logic [7:0]                  o_collision_count
);

  localparam int SW = counter_width(SETTLE_CYCLES - 1);
  localparam int CW = counter_width(COOLDOWN_FRAMES);
  localparam logic [SW-1:0] SETTLE_LOAD   = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] COOLDOWN_LOAD = CW'(COOLDOWN_FRAMES);

  collision_commit_state_t state, state_next;

  logic [SW-1:0] settle_cnt;
  logic          settle_load;
  logic          capture;
  logic          cooldown_load;
  logic          cooldown_tick;
  logic          cooldown_zero;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= CC_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and control strobes
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    settle_load   = 1'b0;
    capture       = 1'b0;
    cooldown_load = 1'b0;
    case (state)
      CC_IDLE: begin
        if (i_frame_tick && i_collision) begin
          state_next  = CC_SETTLE;
          settle_load = 1'b1;
        end
      end
      CC_SETTLE: begin
        // A collision that disappears before settling is dropped silently.
        if (!i_collision) begin
          state_next = CC_IDLE;
        end else if (settle_cnt == '0) begin
          state_next = CC_HOLD;
          capture    = 1'b1;
        end
      end
      CC_HOLD: begin
        if (i_ack) begin
          state_next    = CC_COOLDOWN;
          cooldown_load = 1'b1;
        end
      end
      CC_COOLDOWN: begin
        // The exit cycle is spent here, so a tick coinciding with it cannot
        // start a new settle; the next tick is needed from IDLE.
        if (cooldown_zero) begin
          state_next = CC_IDLE;
        end
      end
      default: begin
        state_next = CC_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Settle counter: loaded on entry, decrements every SETTLE cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      settle_cnt <= '0;
    end else if (settle_load) begin
      settle_cnt <= SETTLE_LOAD;
    end else if ((state == CC_SETTLE) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Cooldown: counts frame ticks only while in COOLDOWN.
  // ---------------------------------------------------------------------------
  assign cooldown_tick = i_frame_tick && (state == CC_COOLDOWN);

  collision_cooldown_timer #(
    .WIDTH (CW)
  ) u_cooldown_timer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_load       (cooldown_load),
    .i_load_value (COOLDOWN_LOAD),
    .i_tick       (cooldown_tick),
    .o_zero       (cooldown_zero)
  );

  // ---------------------------------------------------------------------------
  // Committed result registers: straight copies, held until the next capture.
  // ---------------------------------------------------------------------------
  // NOTE: these data registers carry a reset because the outputs must read
  // zero during reset; pure storage without that need would skip it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_car1_v_x        <= '0;
      o_car1_v_y        <= '0;
      o_car2_v_x        <= '0;
      o_car2_v_y        <= '0;
      o_car1_v_m        <= '0;
      o_car2_v_m        <= '0;
      o_car1_angle      <= '0;
      o_car2_angle      <= '0;
      o_collision_count <= '0;
    end else if (capture) begin
      o_car1_v_x   <= i_car1_v_x;
      o_car1_v_y   <= i_car1_v_y;
      o_car2_v_x   <= i_car2_v_x;
      o_car2_v_y   <= i_car2_v_y;
      o_car1_v_m   <= i_car1_v_m;
      o_car2_v_m   <= i_car2_v_m;
      o_car1_angle <= i_car1_angle;
      o_car2_angle <= i_car2_angle;
      if (o_collision_count != 8'hFF) begin
        o_collision_count <= o_collision_count + 8'd1;
      end
    end
  end

  assign o_valid = (state == CC_HOLD);
  assign o_busy  = (state != CC_IDLE);

endmodule

// File: doc/collision_commit.md
COLLISION_COMMIT -- requirements
Module: collision_commit

Interface
REQ-001 SETTLE_CYCLES, default 40: clock cycles a collision must persist before the result is committed; covers the upstream sqrt/angle iteration latency.
REQ-002 COOLDOWN_FRAMES, default 8: frame ticks during which new collisions are ignored after a commit.
REQ-003 i_clk  in  1  system clock; the only clock.
REQ-004 i_rst_n  in  1  asynchronous active-low reset.
REQ-005 i_frame_tick  in  1  one-cycle pulse per game frame.
REQ-006 i_collision  in  1  collision flag from the upstream collision stage.
REQ-007 i_car1_v_x, i_car1_v_y, i_car2_v_x, i_car2_v_y  in  VW each  signed post-collision velocity components; VW = VELOCITY_INTEGER_WIDTH+VELOCITY_FRACTION_WIDTH.
REQ-008 i_car1_v_m, i_car2_v_m  in  VW each  signed post-collision speed magnitudes.
REQ-009 i_car1_angle, i_car2_angle  in  ANG_WIDTH each  signed heading in degrees, range 0..359.
REQ-010 i_ack  in  1  consumer accepts the committed result.
REQ-011 o_valid  out  1  committed result available.
REQ-012 o_car1_v_x, o_car1_v_y, o_car2_v_x, o_car2_v_y, o_car1_v_m, o_car2_v_m, o_car1_angle, o_car2_angle  out  same widths as inputs  registered committed values.
REQ-013 o_busy  out  1  high in any state other than IDLE.
REQ-014 o_collision_count  out  8  number of committed collisions, saturating.

Function
REQ-015 FSM states are IDLE, SETTLE, HOLD and COOLDOWN; the state register is reset to IDLE.
REQ-016 IDLE -> SETTLE occurs only on a cycle where i_frame_tick=1 and i_collision=1; entry loads the settle counter with SETTLE_CYCLES-1.
REQ-017 In SETTLE the counter decrements each cycle; if i_collision=0 on any SETTLE cycle, the FSM returns to IDLE the next cycle with no capture and no count change.
REQ-018 When the counter is 0 and i_collision=1 in SETTLE, the block captures all eight value inputs into the output registers, increments o_collision_count (saturating at 255), and enters HOLD; total latency from the tick cycle to o_valid=1 is SETTLE_CYCLES+1 cycles.
REQ-019 o_valid=1 exactly while in HOLD; the outputs are stable in HOLD, and input changes do not affect them.
REQ-020 HOLD -> COOLDOWN on the first cycle with i_ack=1; that cycle completes the transfer, entry loads the cooldown counter with COOLDOWN_FRAMES, and o_valid falls the next cycle.
REQ-021 In COOLDOWN the counter decrements only on i_frame_tick; i_collision is ignored; at count 0 the FSM returns to IDLE.
REQ-022 When COOLDOWN_FRAMES=0, COOLDOWN lasts exactly one cycle.
REQ-023 i_frame_tick arriving in the same cycle as the COOLDOWN -> IDLE transition does not start SETTLE; the next tick is required.
REQ-024 i_ack outside HOLD has no effect.
REQ-025 Output value registers retain their last committed values outside HOLD until the next capture.
REQ-026 Capture is a plain register copy: no arithmetic, no width change, and no sign change on any value.

Reset
REQ-027 Asserting i_rst_n low forces, asynchronously: state=IDLE, both counters=0, o_valid=0, all value outputs=0, o_collision_count=0.
REQ-028 Reset asserted mid-SETTLE or mid-HOLD discards the pending result, and no commit occurs after release.
REQ-029 After reset release, the first possible SETTLE entry is on the first qualifying i_frame_tick.

Structure
REQ-030 game_pkg shall hold COLLISION_SETTLE_CYCLES, COLLISION_COOLDOWN_FRAMES and the collision_commit_state_t enum; VW and ANG_WIDTH derive from existing game_pkg constants.
REQ-031 One sub-module, collision_cooldown_timer, implements the frame-tick down counter with load, tick and zero outputs; the settle counter stays inline.

Verification
REQ-032 Tick with i_collision=1 held, SETTLE_CYCLES=40, car1_v_x=0x0123 -> o_valid rises 41 cycles after the tick; o_car1_v_x=0x0123; count=1.
REQ-033 i_collision drops at cycle 20 of SETTLE -> FSM returns to IDLE; o_valid stays 0; count unchanged; outputs unchanged.
REQ-034 Withhold i_ack for 100 cycles while the inputs change -> outputs remain at the captured values; o_valid=1 throughout; one-cycle i_ack -> o_valid=0 on the next cycle.
REQ-035 After ack, i_collision held at 1 and COOLDOWN_FRAMES=8 -> no SETTLE entry until 8 ticks have elapsed plus one further tick.
REQ-036 Assert reset 10 cycles into HOLD -> all outputs read 0 immediately; no o_valid after release until a new full sequence.
REQ-037 Perform 260 complete commit cycles -> o_collision_count saturates at 255.
